// File: rtl/dip_sw_conditioner_pkg.sv
// Shared FSM state encoding and default parameter values for the DIP switch conditioner.
package dip_sw_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESTART = 2'd2
    } state_e;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STABLE_CYCLES  = 1000;
    localparam int DEF_RESTART_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dip_sw_conditioner_sync_chain.sv
// Multi-flop synchroniser for raw asynchronous inputs; latency SYNC_STAGES cycles.
// No backpressure: samples every cycle, resets all stages to zero.
module sync_chain #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/dip_sw_conditioner.sv
// Debounces a bank of DIP switches, commits stable changes and requests a timed core restart.
// Commit latency SYNC_STAGES+STABLE_CYCLES+1 edges; inputs are ignored while restarting.
module dip_sw_conditioner
    import dip_sw_conditioner_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int RESTART_CYCLES = DEF_RESTART_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_stable,
    output logic             changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic             core_rst,
    output logic             busy
);

    localparam int CNT_MAX = max_int(STABLE_CYCLES, RESTART_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end
    if (RESTART_CYCLES < 1) begin : g_bad_restart
        $error("RESTART_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] sampled;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] candidate_q;
    logic [WIDTH-1:0] sw_stable_q;
    logic [WIDTH-1:0] changed_mask_q;
    logic             changed_q;
    logic             core_rst_q;

    sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sw_in),
        .q_o (sampled)
    );

    // core_rst_q mirrors state_q == RESTART but comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RESTART;
            cnt_q          <= '0;
            candidate_q    <= '0;
            sw_stable_q    <= '0;
            changed_mask_q <= '0;
            changed_q      <= 1'b0;
            core_rst_q     <= 1'b1;
        end else begin
            changed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sampled != sw_stable_q) begin
                        candidate_q <= sampled;
                        cnt_q       <= '0;
                        state_q     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sampled != candidate_q) begin
                        candidate_q <= sampled;
                        cnt_q       <= '0;
                    end else if (cnt_q != STABLE_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (candidate_q == sw_stable_q) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        sw_stable_q    <= candidate_q;
                        changed_mask_q <= candidate_q ^ sw_stable_q;
                        changed_q      <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= RESTART;
                        core_rst_q     <= 1'b1;
                    end
                end
                RESTART: begin
                    if (cnt_q == RESTART_LAST) begin
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                        core_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q      <= '0;
                    state_q    <= RESTART;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign sw_stable    = sw_stable_q;
    assign changed      = changed_q;
    assign changed_mask = changed_mask_q;
    assign core_rst     = core_rst_q;
    assign busy         = (state_q != IDLE);

endmodule
